cb_config_sequencer: RTL and testbench

Sequences configuration traffic onto the connection-box config bus (config_addr / config_data / config_en / read_data). Accepts write and read commands from a host over a valid/ready handshake and drives exactly one single-cycle config_en pulse per write. Performs settle-timed readback and returns one response per command. Sits between the global configuration controller and a column of connection boxes sharing one config bus and one muxed read_data return.

---
 rtl/cb_cfg_pkg.sv | 24 ++
 rtl/cb_cfg_err_counter.sv | 30 +++
 rtl/cb_config_sequencer.sv | 171 +++++++++++++++++
 tb/tb_cb_config_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cb_cfg_pkg.sv
// cb_cfg_pkg: shared types and constants for the connection-box config sequencer.
//   cb_cfg_state_e : sequencer FSM states (IDLE, WR, SETTLE, RSP)
//   cb_cfg_cmd_t   : host command record at the default bus widths
//   SETTLE_W       : width of the settle counter (SETTLE_CYCLES up to 15)
package cb_cfg_pkg;

    localparam int unsigned SETTLE_W   = 4;
    localparam int unsigned CMD_ADDR_W = 32;
    localparam int unsigned CMD_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR     = 2'd1,
        SETTLE = 2'd2,
        RSP    = 2'd3
    } cb_cfg_state_e;

    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] data;
    } cb_cfg_cmd_t;

endpackage

// File: rtl/cb_cfg_err_counter.sv
// cb_cfg_err_counter: saturating event counter for verify mismatches.
// Ports:
//   clk   - clock
//   reset - asynchronous active-low clear
//   inc   - count one event this cycle
//   count - current count; sticks at all-ones, never wraps
module cb_cfg_err_counter
    import cb_cfg_pkg::*;
#(
    parameter int unsigned ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    output logic [ERRCNT_W-1:0] count
);

    logic [ERRCNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + ERRCNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cb_config_sequencer.sv
// cb_config_sequencer: drives the shared connection-box config bus from a host
// valid/ready command stream. One config_en pulse per write, settle-timed
// readback for reads, one response per command.
// Build option: CB_CFG_VERIFY_EN adds a readback compare after every write,
// making rsp_err and err_count functional; otherwise both are tied 0.
// Ports:
//   clk, reset                      - clock, async active-low reset
//   cmd_valid/ready/write/addr/data - host command handshake
//   rsp_valid/ready/data/err        - host response handshake
//   config_addr/data/en, read_data  - config bus to the CB column
//   busy                            - FSM not idle
//   err_count                       - saturating verify-mismatch count
// SETTLE_CYCLES must lie in 1..15.
module cb_config_sequencer
    import cb_cfg_pkg::*;
#(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERRCNT_W      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   config_addr,
    output logic [DATA_W-1:0]   config_data,
    output logic                config_en,
    input  logic [DATA_W-1:0]   read_data,
    output logic                busy,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_WR     = WR;
    localparam logic [1:0] S_SETTLE = SETTLE;
    localparam logic [1:0] S_RSP    = RSP;

    localparam logic [SETTLE_W-1:0] SettleLoad = SETTLE_W'(SETTLE_CYCLES - 1);

    logic [1:0]          state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                en_q, en_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

`ifdef CB_CFG_VERIFY_EN
    logic is_wr_q, is_wr_d;
    logic rsp_err_q, rsp_err_d;
    logic err_inc;
`endif

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        addr_d     = addr_q;
        data_d     = data_q;
        en_d       = 1'b0;
        rsp_data_d = rsp_data_q;
`ifdef CB_CFG_VERIFY_EN
        is_wr_d    = is_wr_q;
        rsp_err_d  = rsp_err_q;
        err_inc    = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
`ifdef CB_CFG_VERIFY_EN
                    is_wr_d = cmd_write;
`endif
                    if (cmd_write) begin
                        data_d  = cmd_data;
                        // Strobe is registered so it is high exactly in WR.
                        en_d    = 1'b1;
                        state_d = S_WR;
                    end else begin
                        settle_d = SettleLoad;
                        state_d  = S_SETTLE;
                    end
                end
            end
            S_WR: begin
`ifdef CB_CFG_VERIFY_EN
                settle_d = SettleLoad;
                state_d  = S_SETTLE;
`else
                rsp_data_d = data_q;
                state_d    = S_RSP;
`endif
            end
            S_SETTLE: begin
                if (settle_q == '0) begin
                    rsp_data_d = read_data;
`ifdef CB_CFG_VERIFY_EN
                    rsp_err_d = is_wr_q && (read_data != data_q);
                    err_inc   = is_wr_q && (read_data != data_q);
`endif
                    state_d = S_RSP;
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            settle_q   <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            en_q       <= 1'b0;
            rsp_data_q <= '0;
`ifdef CB_CFG_VERIFY_EN
            is_wr_q    <= 1'b0;
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            en_q       <= en_d;
            rsp_data_q <= rsp_data_d;
`ifdef CB_CFG_VERIFY_EN
            is_wr_q    <= is_wr_d;
            rsp_err_q  <= rsp_err_d;
`endif
        end
    end

`ifdef CB_CFG_VERIFY_EN
    cb_cfg_err_counter #(
        .ERRCNT_W (ERRCNT_W)
    ) u_err_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .count (err_count)
    );

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
    assign err_count = '0;
`endif

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign rsp_valid   = (state_q == S_RSP);
    assign rsp_data    = rsp_data_q;
    assign config_addr = addr_q;
    assign config_data = data_q;
    assign config_en   = en_q;

endmodule

// File: tb/tb_cb_config_sequencer.sv
// Testbench for cb_config_sequencer with a four-register CB model on the bus.
// Latencies are counted as rising edges after the accept edge before rsp_valid
// is first seen (cycle N+1 is the first cycle after the accept edge).
module tb_cb_config_sequencer;
    import cb_cfg_pkg::*;

    localparam int unsigned S = 2;
`ifdef CB_CFG_VERIFY_EN
    localparam int WR_LAT = 1 + S;
`else
    localparam int WR_LAT = 1;
`endif
    localparam int RD_LAT = S;
    localparam logic [7:0] IN_VALS [4] = '{8'd3, 8'd4, 8'd5, 8'd9};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        config_en;
    logic [31:0] read_data;
    logic        busy;
    logic [7:0]  err_count;

    cb_config_sequencer #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .SETTLE_CYCLES (S),
        .ERRCNT_W      (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .config_addr (config_addr),
        .config_data (config_data),
        .config_en   (config_en),
        .read_data   (read_data),
        .busy        (busy),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    // CB model: register file written on config_en, muxed readback,
    // register 0 selects which input drives the CB output.
    logic [31:0] cb_reg [4];
    logic        cb_clear = 1'b1;
    logic        force_mm = 1'b0;
    logic [7:0]  cb_out;

    always @(posedge clk) begin
        if (cb_clear) begin
            for (int i = 0; i < 4; i++) cb_reg[i] <= '0;
        end else if (config_en) begin
            cb_reg[config_addr[1:0]] <= config_data;
        end
    end

    always_comb begin
        read_data = force_mm ? 32'h0 : cb_reg[config_addr[1:0]];
        cb_out    = IN_VALS[cb_reg[0][1:0]];
    end

    int en_pulses = 0;
    always @(negedge clk) if (config_en === 1'b1) en_pulses++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] rd, output logic re,
                           output int en_n);
        int  base;
        bit  got;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_data  = d;
        rsp_ready = 1'b1;
        base      = en_pulses;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        rd  = 'x;
        re  = 1'bx;
        for (int k = 0; k < 64 && !got; k++) begin
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                rd  = rsp_data;
                re  = rsp_err;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        if (!got) lat = -1;
        @(posedge clk);
        @(negedge clk);
        en_n = en_pulses - base;
    endtask

    typedef struct {
        cb_cfg_cmd_t cmd;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_en;
        logic [7:0]  exp_out;
    } vec_t;

    vec_t vecs [8];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int          lat, en_n, base;
        logic [31:0] rd, held;
        logic        re;
        bit          got;

        vecs[0] = '{'{1'b1, 32'h0, 32'h1},        32'h1,        1'b0, WR_LAT, 1, 8'd4};
        vecs[1] = '{'{1'b1, 32'h1, 32'hA5A5_0003}, 32'hA5A5_0003, 1'b0, WR_LAT, 1, 8'd4};
        vecs[2] = '{'{1'b0, 32'h1, 32'h0},        32'hA5A5_0003, 1'b0, RD_LAT, 0, 8'd4};
        vecs[3] = '{'{1'b1, 32'h0, 32'h6},        32'h6,        1'b0, WR_LAT, 1, 8'd5};
        vecs[4] = '{'{1'b0, 32'h0, 32'hDEAD},     32'h6,        1'b0, RD_LAT, 0, 8'd5};
        vecs[5] = '{'{1'b0, 32'h3, 32'h0},        32'h0,        1'b0, RD_LAT, 0, 8'd5};
        vecs[6] = '{'{1'b1, 32'h2, 32'hFFFF_FFFF}, 32'hFFFF_FFFF, 1'b0, WR_LAT, 1, 8'd5};
        vecs[7] = '{'{1'b0, 32'h2, 32'h0},        32'hFFFF_FFFF, 1'b0, RD_LAT, 0, 8'd5};

        // Reset state
        #12;
        check("rst_config_addr", config_addr, 0);
        check("rst_config_data", config_data, 0);
        check("rst_config_en", config_en, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cb_clear = 1'b0;
        reset    = 1'b1;
        @(negedge clk);

        // Table-driven commands
        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].cmd.write, vecs[i].cmd.addr, vecs[i].cmd.data, lat, rd, re, en_n);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_rsp_data", i), rd, vecs[i].exp_data);
            check($sformatf("vec%0d_rsp_err", i), re, vecs[i].exp_err);
            check($sformatf("vec%0d_config_en_pulses", i), 64'(en_n), 64'(vecs[i].exp_en));
            check($sformatf("vec%0d_cb_out", i), cb_out, vecs[i].exp_out);
        end

        // Address/data hold in IDLE; a read leaves config_data alone
        check("idle_config_addr_held", config_addr, 32'h2);
        check("idle_config_data_held", config_data, 32'hFFFF_FFFF);
        check("idle_config_en_low", config_en, 0);

        // Backpressure: response held while rsp_ready is low
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h1;
        cmd_data  = 32'h0000_0BEE;
        rsp_ready = 1'b0;
        base      = en_pulses;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
            if (rsp_valid === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        check("bp_rsp_valid_seen", got, 1);
        held = rsp_data;
        check("bp_rsp_data", held, 32'h0000_0BEE);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_rsp_valid", k), rsp_valid, 1);
            check($sformatf("bp_hold%0d_cmd_ready", k), cmd_ready, 0);
            check($sformatf("bp_hold%0d_rsp_data", k), rsp_data, 32'h0000_0BEE);
        end
        check("bp_config_en_pulses", 64'(en_pulses - base), 1);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_done_rsp_valid", rsp_valid, 0);
        check("bp_done_cmd_ready", cmd_ready, 1);

        // Reset asserted during the WR cycle
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0;
        cmd_data  = 32'h1;
        @(posedge clk);
        #2;
        check("wr_rst_config_en_before", config_en, 1);
        reset = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check("wr_rst_config_en", config_en, 0);
        check("wr_rst_busy", busy, 0);
        check("wr_rst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("wr_rst_cmd_ready_after", cmd_ready, 1);
        check("wr_rst_busy_after", busy, 0);
        got = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) got = 1'b1;
        end
        check("wr_rst_no_response", got, 0);
        check("wr_rst_cb_not_written", cb_reg[0], 32'h6);

        // Forced readback mismatch
        force_mm = 1'b1;
        run_cmd(1'b1, 32'h0, 32'h0000_0070, lat, rd, re, en_n);
        check("mm_latency", 64'(lat), 64'(WR_LAT));
`ifdef CB_CFG_VERIFY_EN
        check("mm_rsp_data", rd, 32'h0);
        check("mm_rsp_err", re, 1);
        check("mm_err_count", err_count, 1);
`else
        check("mm_rsp_data", rd, 32'h0000_0070);
        check("mm_rsp_err", re, 0);
        check("mm_err_count", err_count, 0);
`endif
        for (int k = 0; k < 299; k++) begin
            run_cmd(1'b1, 32'h0, 32'h0000_0070, lat, rd, re, en_n);
        end
`ifdef CB_CFG_VERIFY_EN
        check("mm_err_count_saturated", err_count, 8'd255);
`else
        check("mm_err_count_tied", err_count, 8'd0);
`endif
        force_mm = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_clears_err_count", err_count, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
